data_memory_arbiter: RTL and testbench

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

---
 rtl/data_memory_arbiter_pkg.sv | 13 +
 rtl/data_memory_arbiter_rr_arb2.sv | 16 +
 rtl/data_memory_arbiter.sv | 116 +++++++++++
 tb/tb_data_memory_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// rtl/data_memory_arbiter_pkg.sv - shared state encoding and default widths for the memory arbiter
package data_memory_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/data_memory_arbiter_rr_arb2.sv
// rtl/data_memory_arbiter_rr_arb2.sv - two-way round-robin pick
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic id,
  output logic valid
);

  // A lone request wins outright; a tie goes to the requester named by ptr.
  always_comb begin
    valid = req0 | req1;
    id    = (req0 & req1) ? ptr : req1;
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - shares one single-port data memory between two requesters
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t            state;
  logic              ptr;
  logic              lat_id;
  logic              lat_we;

  logic              win_id;
  logic              win_valid;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  rr_arb2 u_rr_arb2 (
    .req0  (req0),
    .req1  (req1),
    .ptr   (ptr),
    .id    (win_id),
    .valid (win_valid)
  );

  always_comb begin
    win_we    = win_id ? we1    : we0;
    win_addr  = win_id ? addr1  : addr0;
    win_wdata = win_id ? wdata1 : wdata0;
  end

  // mem_add/mem_din double as the latched address and write data; they are
  // loaded on the sampling edge and cleared when BUSY ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      lat_id  <= 1'b0;
      lat_we  <= 1'b0;
      rdata   <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      mem_wr  <= 1'b0;
      mem_rd  <= 1'b0;
      mem_add <= '0;
      mem_din <= '0;
    end else begin
      case (state)
        IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (win_valid) begin
            lat_id  <= win_id;
            lat_we  <= win_we;
            gnt0    <= ~win_id;
            gnt1    <= win_id;
            mem_wr  <= win_we;
            mem_rd  <= ~win_we;
            mem_add <= win_addr;
            mem_din <= win_wdata;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!lat_we) begin
            rdata <= mem_dout;
          end
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          mem_wr  <= 1'b0;
          mem_rd  <= 1'b0;
          mem_add <= '0;
          mem_din <= '0;
          done0   <= ~lat_id;
          done1   <= lat_id;
          state   <= DONE;
        end
        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          ptr   <= ~lat_id;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - directed self-checking bench for data_memory_arbiter
module tb_data_memory_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] rdata;
  logic       mem_wr, mem_rd;
  logic [7:0] mem_add, mem_din;
  wire  [7:0] mem_dout;

  logic [7:0] mem [256];
  logic       mem_init;

  int n_pass;
  int n_total;
  int cyc;

  data_memory_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .done0    (done0),
    .done1    (done1),
    .rdata    (rdata),
    .mem_wr   (mem_wr),
    .mem_rd   (mem_rd),
    .mem_add  (mem_add),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-write memory with a tri-stated read port.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[255] <= 8'h3C;
    end else if (mem_wr) begin
      mem[mem_add] <= mem_din;
    end
  end
  assign mem_dout = mem_rd ? mem[mem_add] : 8'bz;

  always @(negedge clk) begin
    if ((gnt0 && gnt1) || (mem_wr && mem_rd)) begin
      $display("FAIL exclusivity: gnt0=%0b gnt1=%0b mem_wr=%0b mem_rd=%0b required no pair both high",
               gnt0, gnt1, mem_wr, mem_rd);
      n_total++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic       r0, w0;
    logic [7:0] a0, d0;
    logic       r1, w1;
    logic [7:0] a1, d1;
    logic       id;
    logic [7:0] add, din;
    logic       wr;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs [8];

  // One full transaction from IDLE: sample, BUSY checks, DONE checks, back in IDLE.
  task automatic apply_vec(input vec_t v, input int n);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    @(posedge clk); #1;
    check($sformatf("v%0d busy gnt0", n), gnt0, !v.id);
    check($sformatf("v%0d busy gnt1", n), gnt1, v.id);
    check($sformatf("v%0d busy mem_add", n), mem_add, v.add);
    check($sformatf("v%0d busy mem_din", n), mem_din, v.din);
    check($sformatf("v%0d busy mem_wr", n), mem_wr, v.wr);
    check($sformatf("v%0d busy mem_rd", n), mem_rd, !v.wr);
    check($sformatf("v%0d busy done", n), {done1, done0}, 2'b00);
    @(posedge clk); #1;
    check($sformatf("v%0d done0", n), done0, !v.id);
    check($sformatf("v%0d done1", n), done1, v.id);
    check($sformatf("v%0d rdata", n), rdata, v.rd);
    check($sformatf("v%0d done gnt/mem", n), {gnt1, gnt0, mem_wr, mem_rd}, 4'b0000);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    check($sformatf("v%0d idle outs", n), {gnt1, gnt0, done1, done0, mem_wr, mem_rd}, 6'b0);
    check($sformatf("v%0d idle mem_add", n), mem_add, 8'h00);
  endtask

  initial begin
    vec_t h;
    int   k;
    int   last_cyc;
    logic win;

    n_pass = 0; n_total = 0; cyc = 0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    rst = 1'b1; mem_init = 1'b1;

    //          r0 w0 a0     d0     r1 w1 a1     d1     id add    din    wr rd
    vecs[0] = '{1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 0, 8'h10, 8'hA5, 1, 8'h00};
    vecs[1] = '{1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h10, 8'h00, 0, 8'hA5};
    vecs[2] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h00, 1, 8'hFF, 8'h00, 0, 8'h3C};
    vecs[3] = '{1, 1, 8'h30, 8'h11, 1, 1, 8'h31, 8'h22, 0, 8'h30, 8'h11, 1, 8'h3C};
    vecs[4] = '{1, 0, 8'h31, 8'h00, 1, 0, 8'h30, 8'h00, 1, 8'h30, 8'h00, 0, 8'h11};
    vecs[5] = '{1, 0, 8'h10, 8'h00, 1, 0, 8'hFF, 8'h00, 0, 8'h10, 8'h00, 0, 8'hA5};
    vecs[6] = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 8'h77, 1, 8'h40, 8'h77, 1, 8'hA5};
    vecs[7] = '{1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h40, 8'h00, 0, 8'h77};

    @(posedge clk); #1;
    mem_init = 1'b0;
    check("reset outs", {gnt1, gnt0, done1, done0, mem_wr, mem_rd}, 6'b0);
    check("reset rdata", rdata, 8'h00);
    check("reset mem_add", mem_add, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);

    // Requester drops req and moves addr right after the sampling edge.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h40;
    @(posedge clk); #1;
    req0 = 1'b0; addr0 = 8'h55; we0 = 1'b1;
    #1;
    check("drop busy mem_add", mem_add, 8'h40);
    check("drop busy mem_rd", mem_rd, 1'b1);
    @(posedge clk); #1;
    check("drop done0", done0, 1'b1);
    check("drop rdata", rdata, 8'h77);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("drop no new gnt", {gnt1, gnt0}, 2'b00);

    // Reset mid-BUSY of a write to 0x20 must abort it asynchronously.
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h99;
    @(posedge clk); #1;
    check("abort busy mem_wr", mem_wr, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("abort async outs", {gnt1, gnt0, done1, done0, mem_wr, mem_rd}, 6'b0);
    check("abort async rdata", rdata, 8'h00);
    check("abort async mem_add", mem_add, 8'h00);
    req0 = 1'b0; we0 = 1'b0; wdata0 = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    h = '{1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h10, 8'h00, 0, 8'hA5};
    apply_vec(h, 100);
    h = '{1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h20, 8'h00, 0, 8'h00};
    apply_vec(h, 101);

    // Both requesters held continuously from reset: grants alternate 0,1,0,1 every 3 cycles.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'hFF;
    last_cyc = 0;
    for (int t = 0; t < 4; t++) begin
      k = 0;
      while (!(gnt0 || gnt1) && k < 10) begin
        @(posedge clk); #1;
        k++;
      end
      if (k == 10) begin
        check($sformatf("rr t%0d gnt timeout", t), 1'b0, 1'b1);
      end else begin
        win = gnt1;
        check($sformatf("rr t%0d winner", t), win, t[0]);
        if (t > 0) check($sformatf("rr t%0d spacing", t), cyc - last_cyc, 3);
        last_cyc = cyc;
        @(posedge clk); #1;
        check($sformatf("rr t%0d done", t), {done1, done0}, t[0] ? 2'b10 : 2'b01);
        check($sformatf("rr t%0d rdata", t), rdata, t[0] ? 8'h3C : 8'hA5);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
